ula_mc: RTL and testbench
=========================

# ula_mc

Multi-cycle, parametrised successor to the single-cycle ULA. It keeps the base logic/arithmetic operations at one-cycle registered latency and adds unsigned multiply and divide (low/high product, quotient, remainder) as iterative WIDTH-cycle operations. It sits in the execute stage. The control unit launches an operation with `start` and stalls the pipeline while `busy` is high.

## Interface
- `WIDTH`, default 32, operand and result width (≥ 4).
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: launch request, sampled only when `busy`=0.
- `A` input WIDTH: operand A, captured when the launch is accepted.
- `B` input WIDTH: operand B, captured when the launch is accepted.
- `UlaOp` input 4: operation code, captured when the launch is accepted.
- `S` output WIDTH: registered result, held until the next completion.
- `Zero` output 1: registered, equals (S == 0).
- `busy` output 1: high while a multi-cycle operation iterates.
- `done` output 1: one-cycle pulse marking that S and Zero were updated.

## Operation
- Single-cycle ops (UlaOp):
  - 0000 AND
  - 0001 OR
  - 0011 XOR
  - 0010 ADD
  - 0110 SUB
  - 0111 SLTU (S = A<B unsigned ? 1 : 0)
- Multi-cycle ops:
  - 1000 MUL: low WIDTH bits of A*B.
  - 1001 MULHU: high WIDTH bits of the unsigned 2·WIDTH-bit product.
  - 1010 DIVU: unsigned quotient.
  - 1011 REMU: unsigned remainder.
- Any other code is undefined: it completes as a single-cycle op with S=0 and Zero=1.
- Arithmetic rules:
  - ADD and SUB wrap modulo 2^WIDTH.
  - No overflow or carry outputs.
  - All operations are unsigned.
- State machine states:
  - IDLE: waits for a launch.
  - MUL: iterative shift-add multiply.
  - DIV: iterative restoring divide.
- Launch acceptance: in IDLE with `start`=1, the block captures A, B and UlaOp.
- Transitions from IDLE on an accepted launch:
  - Single-cycle op, undefined op, or divide by zero: S and Zero are written at the same edge, `done` pulses, and the FSM stays in IDLE.
  - Multiply op: go to MUL, set `busy`=1, clear the iteration counter.
  - Divide op with B≠0: go to DIV, set `busy`=1, clear the iteration counter.
- MUL: one multiplier bit per cycle, LSB first, into a 2·WIDTH-bit accumulator. After WIDTH iterations, write the selected half to S and return to IDLE.
- DIV: one quotient bit per cycle, MSB first, restoring subtraction on a WIDTH+1-bit partial remainder. After WIDTH iterations, write the quotient or remainder to S and return to IDLE.
- Divide by zero (RISC-V semantics):
  - DIVU: S = all ones.
  - REMU: S = A.
  - Completes in one cycle and never enters DIV.
- `start` while `busy`=1 is ignored. It is not queued, and the in-flight operation is unaffected.
- Operand inputs may change freely after acceptance. Only the captured copies are used.

## Timing
- Reset (asynchronous, rst_n=0):
  - State returns to IDLE immediately.
  - S=0, Zero=1, busy=0, done=0.
  - The iteration counter and internal registers are cleared.
- Reset asserted mid-operation aborts the operation. No `done` pulse is produced for it.
- Launch accepted at rising edge k:
  - Single-cycle, undefined or divide-by-zero op: S, Zero valid and `done`=1 during cycle k+1. `done` returns to 0 after edge k+1 unless a new launch is accepted at edge k+1.
  - Multi-cycle op: `busy`=1 during cycles k+1 … k+WIDTH. At edge k+WIDTH, `busy` falls, S and Zero update, and `done`=1 during cycle k+WIDTH+1. Total latency is WIDTH cycles.
- Back-to-back launches:
  - A new launch may be accepted at the edge immediately after `busy` falls.
  - Single-cycle ops can be accepted every cycle, giving `done` high continuously.
- S and Zero change only on a completion edge or on reset.

## Test plan
- Reset, then with WIDTH=32, A=20, B=12, launch each single-cycle op in consecutive cycles:
  - AND → 4
  - OR → 28
  - XOR → 24
  - ADD → 32
  - SUB → 8
  - SLTU → 0
  - Each result appears one cycle after its launch with `done`=1 and `busy`=0 throughout.
- MUL with A=20, B=12 → S=240 after 32 cycles of `busy`; `done` pulses exactly once.
- MULHU with A=B=0xFFFFFFFF → S=0xFFFFFFFE. MUL with the same operands → S=0x00000001.
- DIVU and REMU:
  - A=20, B=12: DIVU → 1, REMU → 8.
  - A=20, B=0: DIVU → 0xFFFFFFFF, REMU → 20, each in 1 cycle with no `busy`.
- Pulse `start` with SUB at cycle 5 of a running MUL → MUL result is unaffected and SUB is not executed. Undefined op 1111 → S=0, Zero=1.
- Assert `rst_n`=0 mid-DIVU → busy=0, S=0, Zero=1 immediately, with no `done` pulse. A fresh DIVU launch after release completes correctly.

Source files
------------

// File: rtl/ula_mc.sv
// Multi-cycle unsigned ALU: one-cycle logic/add/sub/sltu plus iterative
// shift-add multiply and restoring divide, each taking WIDTH cycles.
module ula_mc #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       UlaOp,
    output logic [WIDTH-1:0] S,
    output logic             Zero,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_DIVU = 4'b1010;
    localparam logic [3:0] OP_REMU = 4'b1011;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_s, w_s_nxt;
    logic               r_zero, w_zero_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic               r_sel, w_sel_nxt;
    logic [WIDTH-1:0]   r_a, w_a_nxt;
    logic [WIDTH-1:0]   r_b, w_b_nxt;
    logic [2*WIDTH-1:0] r_acc, w_acc_nxt;
    logic [WIDTH-1:0]   r_rem, w_rem_nxt;
    logic [WIDTH-1:0]   r_q, w_q_nxt;

    logic [WIDTH-1:0]   w_alu;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_step;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ok;
    logic [WIDTH-1:0]   w_div_rem;
    logic [WIDTH-1:0]   w_div_q;
    logic               w_last;

    // Single-cycle results; divide-by-zero values are only reached with B == 0
    always_comb begin
        w_alu = '0;
        case (UlaOp)
            OP_AND:  w_alu = A & B;
            OP_OR:   w_alu = A | B;
            OP_XOR:  w_alu = A ^ B;
            OP_ADD:  w_alu = A + B;
            OP_SUB:  w_alu = A - B;
            OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_DIVU: w_alu = '1;
            OP_REMU: w_alu = A;
            default: w_alu = '0;
        endcase
    end

    // Multiplier bit consumed from acc[0]; sum carries into the shifted-in top bit
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

    assign w_div_shift = {r_rem, r_q[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_b};
    assign w_div_ok    = ~w_div_diff[WIDTH];
    assign w_div_rem   = w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
    assign w_div_q     = {r_q[WIDTH-2:0], w_div_ok};

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_zero_nxt  = r_zero;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_acc_nxt   = r_acc;
        w_rem_nxt   = r_rem;
        w_q_nxt     = r_q;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_a_nxt   = A;
                    w_b_nxt   = B;
                    w_sel_nxt = UlaOp[0];
                    if (UlaOp[3:1] == 3'b100) begin
                        w_state_nxt = ST_MUL;
                        w_busy_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_acc_nxt   = {{WIDTH{1'b0}}, B};
                    end else if (UlaOp[3:1] == 3'b101 && B != '0) begin
                        w_state_nxt = ST_DIV;
                        w_busy_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_rem_nxt   = '0;
                        w_q_nxt     = A;
                    end else begin
                        w_s_nxt    = w_alu;
                        w_done_nxt = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                w_acc_nxt = w_mul_step;
                w_cnt_nxt = r_cnt + CW'(1);
                if (w_last) begin
                    w_s_nxt     = r_sel ? w_mul_step[2*WIDTH-1:WIDTH] : w_mul_step[WIDTH-1:0];
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DIV: begin
                w_rem_nxt = w_div_rem;
                w_q_nxt   = w_div_q;
                w_cnt_nxt = r_cnt + CW'(1);
                if (w_last) begin
                    w_s_nxt     = r_sel ? w_div_rem : w_div_q;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
        w_zero_nxt = (w_s_nxt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s    <= '0;
            r_zero <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
            r_sel  <= 1'b0;
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_rem  <= '0;
            r_q    <= '0;
        end else begin
            r_s    <= w_s_nxt;
            r_zero <= w_zero_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            r_cnt  <= w_cnt_nxt;
            r_sel  <= w_sel_nxt;
            r_a    <= w_a_nxt;
            r_b    <= w_b_nxt;
            r_acc  <= w_acc_nxt;
            r_rem  <= w_rem_nxt;
            r_q    <= w_q_nxt;
        end
    end

    assign S    = r_s;
    assign Zero = r_zero;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_ula_mc.sv
// Directed bench for ula_mc (WIDTH=32) with hand-computed expected values.
module tb_ula_mc;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  UlaOp;
    logic [31:0] S;
    logic        Zero;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    ula_mc #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .UlaOp (UlaOp),
        .S     (S),
        .Zero  (Zero),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a launch at a falling edge; returns at the falling edge after the accepting edge
    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        UlaOp = op;
        A     = a;
        B     = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic single(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        launch(op, a, b);
        chk({tag, "_S"}, S, exp);
        chk({tag, "_zero"}, 32'(Zero), 32'(exp == 32'd0));
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic multi(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] prev,
                         input logic [31:0] exp, input bit inject);
        int          n_busy;
        int          n_done;
        logic [31:0] s_got;
        n_busy = 0;
        n_done = 0;
        s_got  = 32'hDEAD_BEEF;
        launch(op, a, b);
        A = $urandom;
        B = $urandom;
        chk({tag, "_S_held"}, S, prev);
        for (int i = 0; i < 40; i++) begin
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                s_got = S;
            end
            if (inject && i == 4) begin
                UlaOp = 4'b0110;
                A     = 32'd50;
                B     = 32'd3;
                start = 1'b1;
            end
            if (i == 5) start = 1'b0;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 32'(n_busy), 32'd32);
        chk({tag, "_done_pulses"}, 32'(n_done), 32'd1);
        chk({tag, "_S"}, s_got, exp);
        chk({tag, "_S_after"}, S, exp);
        chk({tag, "_zero"}, 32'(Zero), 32'(exp == 32'd0));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        UlaOp = '0;
        @(negedge clk);
        chk("rst_S", S, 32'd0);
        chk("rst_zero", 32'(Zero), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back single-cycle ops
        single("and",  4'b0000, 32'd20, 32'd12, 32'd4);
        single("or",   4'b0001, 32'd20, 32'd12, 32'd28);
        single("xor",  4'b0011, 32'd20, 32'd12, 32'd24);
        single("add",  4'b0010, 32'd20, 32'd12, 32'd32);
        single("sub",  4'b0110, 32'd20, 32'd12, 32'd8);
        single("sltu", 4'b0111, 32'd20, 32'd12, 32'd0);
        @(negedge clk);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_S", S, 32'd0);
        single("sub_wrap",  4'b0110, 32'd3, 32'd5, 32'hFFFF_FFFE);
        single("sltu_true", 4'b0111, 32'd12, 32'd20, 32'd1);

        multi("mul",   4'b1000, 32'd20, 32'd12, 32'd1, 32'd240, 1'b1);
        multi("mulhu", 4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd240, 32'hFFFF_FFFE, 1'b0);
        multi("mulff", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 1'b0);
        multi("divu",  4'b1010, 32'd20, 32'd12, 32'd1, 32'd1, 1'b0);
        multi("remu",  4'b1011, 32'd20, 32'd12, 32'd1, 32'd8, 1'b0);
        multi("remu0", 4'b1011, 32'd24, 32'd12, 32'd8, 32'd0, 1'b0);

        single("divu_by0", 4'b1010, 32'd20, 32'd0, 32'hFFFF_FFFF);
        single("remu_by0", 4'b1011, 32'd20, 32'd0, 32'd20);
        single("undef_f",  4'b1111, 32'd20, 32'd12, 32'd0);
        single("add_mid",  4'b0010, 32'd7, 32'd9, 32'd16);
        single("undef_c",  4'b1100, 32'd20, 32'd12, 32'd0);
        single("add_pre",  4'b0010, 32'd7, 32'd9, 32'd16);

        // Reset in the middle of a divide
        launch(4'b1010, 32'd100, 32'd7);
        chk("divrst_busy_on", 32'(busy), 32'd1);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("divrst_busy", 32'(busy), 32'd0);
        chk("divrst_S", S, 32'd0);
        chk("divrst_zero", 32'(Zero), 32'd1);
        chk("divrst_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("divrst_done_held", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        multi("divu_post", 4'b1010, 32'd100, 32'd7, 32'd0, 32'd14, 1'b0);
        multi("remu_post", 4'b1011, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
